// File: rtl/fwrisc_formal_pkg.sv
// Shared types and RV32I encoding helpers for the fwrisc formal bus responder.
package fwrisc_formal_pkg;

  typedef enum logic [2:0] {
    MODE_ADD  = 3'd0,
    MODE_SUB  = 3'd1,
    MODE_AND  = 3'd2,
    MODE_OR   = 3'd3,
    MODE_XOR  = 3'd4,
    MODE_ADDI = 3'd5
  } mode_e;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_AND = 3'd7;
  localparam logic [2:0] F3_OR  = 3'd6;
  localparam logic [2:0] F3_XOR = 3'd4;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_SUB  = 7'h20;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_WAIT = 1'b1
  } ch_state_e;

  // Unlisted modes (6, 7) fall back to ADD.
  function automatic logic [31:0] encode_instr(input logic [2:0]  mode,
                                               input logic [4:0]  rs1,
                                               input logic [4:0]  rs2,
                                               input logic [4:0]  rd,
                                               input logic [11:0] imm);
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] instr;
    f7 = F7_BASE;
    f3 = F3_ADD;
    case (mode)
      MODE_SUB: f7 = F7_SUB;
      MODE_AND: f3 = F3_AND;
      MODE_OR:  f3 = F3_OR;
      MODE_XOR: f3 = F3_XOR;
      default:  ;
    endcase
    if (mode == MODE_ADDI) instr = {imm, rs1, F3_ADD, rd, OP_ITYPE};
    else                   instr = {f7, rs2, rs1, f3, rd, OP_RTYPE};
    return instr;
  endfunction

endpackage

// File: rtl/fwrisc_formal_wait_resp.sv
// Single-channel responder: bounded wait insertion plus dropped-request check.
module fwrisc_formal_wait_resp
  import fwrisc_formal_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 3,
  parameter int unsigned WAIT_W   = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              hold_i,
  input  logic              valid_i,
  input  logic [WAIT_W-1:0] wait_sel_i,
  output logic              ready_o,
  output logic              err_o
);

  localparam int unsigned CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_c;
  logic             err_q, err_d;

  always_comb begin
    if (32'(wait_sel_i) > MAX_WAIT) n_c = CNT_W'(MAX_WAIT);
    else                            n_c = CNT_W'(wait_sel_i);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ready_o = 1'b0;
    if (hold_i) begin
      state_d = CH_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        CH_IDLE: begin
          if (valid_i) begin
            if (n_c == '0) begin
              ready_o = 1'b1;
            end else begin
              cnt_d   = n_c - CNT_W'(1);
              state_d = CH_WAIT;
            end
          end
        end
        CH_WAIT: begin
          // Requester withdrew before the response: flag it and abandon.
          if (!valid_i) begin
            err_d   = 1'b1;
            state_d = CH_IDLE;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            ready_o = 1'b1;
            state_d = CH_IDLE;
          end
        end
        default: state_d = CH_IDLE;
      endcase
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/fwrisc_formal_bus_responder.sv
// Bus responder and instruction stimulus encoder for fwrisc formal/sim benches.
module fwrisc_formal_bus_responder
  import fwrisc_formal_pkg::*;
#(
  parameter int unsigned MAX_WAIT     = 3,
  parameter int unsigned WAIT_W       = 2,
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned MAX_INSTR    = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              core_reset,
  input  logic [31:0]       iaddr,
  input  logic              ivalid,
  output logic [31:0]       idata,
  output logic              iready,
  input  logic [31:0]       daddr,
  input  logic [31:0]       dwdata,
  input  logic [3:0]        dstrb,
  input  logic              dwrite,
  input  logic              dvalid,
  output logic [31:0]       drdata,
  output logic              dready,
  input  logic [2:0]        mode,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic [11:0]       imm,
  input  logic [31:0]       rdata_src,
  input  logic [WAIT_W-1:0] iwait,
  input  logic [WAIT_W-1:0] dwait,
  output logic [31:0]       instr_count,
  output logic              done,
  output logic              wr_valid,
  output logic [31:0]       wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  output logic              protocol_err
);

  localparam int unsigned RST_W = $clog2(RESET_CYCLES + 2);

  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic             core_reset_q, core_reset_d;
  logic [31:0]      instr_count_q, instr_count_d;
  logic             done_q, done_d;
  logic             wr_valid_q, wr_valid_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic [3:0]       wr_strb_q, wr_strb_d;
  logic             i_err_c, d_err_c;
  logic             store_c;
  logic             unused_iaddr_c;

  // Fetch address is not decoded; stimulus comes purely from the mode fields.
  assign unused_iaddr_c = ^iaddr;

  fwrisc_formal_wait_resp #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_iresp (
    .clock      (clock),
    .reset_n    (reset_n),
    .hold_i     (core_reset_q | done_q),
    .valid_i    (ivalid),
    .wait_sel_i (iwait),
    .ready_o    (iready),
    .err_o      (i_err_c)
  );

  fwrisc_formal_wait_resp #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_dresp (
    .clock      (clock),
    .reset_n    (reset_n),
    .hold_i     (core_reset_q),
    .valid_i    (dvalid),
    .wait_sel_i (dwait),
    .ready_o    (dready),
    .err_o      (d_err_c)
  );

  assign store_c = dvalid & dready & dwrite;

  always_comb begin
    rst_cnt_d     = rst_cnt_q;
    core_reset_d  = core_reset_q;
    instr_count_d = instr_count_q;
    done_d        = done_q;
    wr_valid_d    = store_c;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    wr_strb_d     = wr_strb_q;
    // Core reset stays high for RESET_CYCLES edges after reset_n releases.
    if (core_reset_q) begin
      rst_cnt_d    = rst_cnt_q + RST_W'(1);
      core_reset_d = (32'(rst_cnt_q) + 32'd1) < RESET_CYCLES;
    end
    if (ivalid && iready) instr_count_d = instr_count_q + 32'd1;
    done_d = done_q | ((MAX_INSTR != 32'd0) && (instr_count_d == MAX_INSTR));
    if (store_c) begin
      wr_addr_d = daddr;
      wr_data_d = dwdata;
      wr_strb_d = dstrb;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_cnt_q     <= '0;
      core_reset_q  <= 1'b1;
      instr_count_q <= '0;
      done_q        <= 1'b0;
      wr_valid_q    <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_strb_q     <= '0;
    end else begin
      rst_cnt_q     <= rst_cnt_d;
      core_reset_q  <= core_reset_d;
      instr_count_q <= instr_count_d;
      done_q        <= done_d;
      wr_valid_q    <= wr_valid_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wr_strb_q     <= wr_strb_d;
    end
  end

  assign core_reset   = core_reset_q;
  assign idata        = encode_instr(mode, rs1, rs2, rd, imm);
  assign drdata       = rdata_src;
  assign instr_count  = instr_count_q;
  assign done         = done_q;
  assign wr_valid     = wr_valid_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign wr_strb      = wr_strb_q;
  assign protocol_err = i_err_c | d_err_c;

endmodule

// File: tb/tb_fwrisc_formal_bus_responder.sv
// Self-checking bench: fetch encoding table, wait/clamp, store capture, limit, violation, abort.
module tb_fwrisc_formal_bus_responder;

  localparam int unsigned MAX_WAIT     = 2;
  localparam int unsigned WAIT_W       = 2;
  localparam int unsigned RESET_CYCLES = 2;
  localparam int unsigned MAX_INSTR    = 4;

  logic        clock;
  logic        reset_n;
  logic        core_reset;
  logic [31:0] iaddr;
  logic        ivalid;
  logic [31:0] idata;
  logic        iready;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dstrb;
  logic        dwrite;
  logic        dvalid;
  logic [31:0] drdata;
  logic        dready;
  logic [2:0]  mode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [11:0] imm;
  logic [31:0] rdata_src;
  logic [1:0]  iwait;
  logic [1:0]  dwait;
  logic [31:0] instr_count;
  logic        done;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        protocol_err;

  fwrisc_formal_bus_responder #(
    .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W), .RESET_CYCLES(RESET_CYCLES), .MAX_INSTR(MAX_INSTR)
  ) dut (
    .clock(clock), .reset_n(reset_n), .core_reset(core_reset),
    .iaddr(iaddr), .ivalid(ivalid), .idata(idata), .iready(iready),
    .daddr(daddr), .dwdata(dwdata), .dstrb(dstrb), .dwrite(dwrite), .dvalid(dvalid),
    .drdata(drdata), .dready(dready),
    .mode(mode), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .rdata_src(rdata_src),
    .iwait(iwait), .dwait(dwait),
    .instr_count(instr_count), .done(done),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .protocol_err(protocol_err)
  );

  typedef struct {
    logic [2:0]  mode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] imm;
    logic [1:0]  wsel;
    int          lat;
    logic [31:0] exp;
  } ivec_t;

  ivec_t       vecs[9];
  logic [31:0] iexp_q[$];
  logic [31:0] dexp_q[$];
  int          tests;
  int          fails;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset_n = 1'b0;
    ivalid = 1'b1; iwait = 2'd0;
    dvalid = 1'b1; dwait = 2'd0; dwrite = 1'b0;
    @(negedge clock);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_ready", 32'({iready, dready}), 32'd0);
    check("rst_flags", 32'({done, wr_valid, protocol_err}), 32'd0);
    check("rst_instr_count", instr_count, 32'd0);
    check("rst_wr_addr", wr_addr, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_wr_strb", 32'(wr_strb), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("hold0_core_reset", 32'(core_reset), 32'd1);
    @(posedge clock); #1;
    @(negedge clock);
    check("hold1_core_reset", 32'(core_reset), 32'd1);
    check("hold1_ready", 32'({iready, dready}), 32'd0);
    check("hold1_count", instr_count, 32'd0);
    @(posedge clock); #1;
    ivalid = 1'b0; dvalid = 1'b0;
    @(negedge clock);
    check("rel_core_reset", 32'(core_reset), 32'd0);
  endtask

  task automatic fetch(input ivec_t v, input int idx, input int exp_cnt);
    bit          seen;
    int          lat;
    logic [31:0] e;
    @(posedge clock); #1;
    mode = v.mode; rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; imm = v.imm;
    iwait = v.wsel; ivalid = 1'b1;
    iexp_q.push_back(v.exp);
    seen = 1'b0; lat = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (iready) begin seen = 1'b1; lat = c; break; end
    end
    e = (iexp_q.size() > 0) ? iexp_q.pop_front() : 32'hx;
    if (!seen) begin
      check($sformatf("fetch%0d_timeout", idx), 32'(iready), 32'd1);
    end else begin
      check($sformatf("fetch%0d_idata", idx), idata, e);
      check($sformatf("fetch%0d_lat", idx), 32'(lat), 32'(v.lat));
    end
    @(posedge clock); #1;
    ivalid = 1'b0;
    @(negedge clock);
    check($sformatf("fetch%0d_count", idx), instr_count, 32'(exp_cnt));
    check($sformatf("fetch%0d_done", idx), 32'(done), 32'(exp_cnt == 4));
  endtask

  task automatic dreq(input string name, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb, input logic [1:0] w,
                      input logic [31:0] src, input int exp_lat);
    bit          seen;
    int          lat;
    logic [31:0] e;
    @(posedge clock); #1;
    dwrite = wr; daddr = addr; dwdata = wdata; dstrb = strb; dwait = w; rdata_src = src;
    dvalid = 1'b1;
    dexp_q.push_back(src);
    seen = 1'b0; lat = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (dready) begin seen = 1'b1; lat = c; break; end
    end
    e = (dexp_q.size() > 0) ? dexp_q.pop_front() : 32'hx;
    if (!seen) begin
      check({name, "_timeout"}, 32'(dready), 32'd1);
    end else begin
      check({name, "_lat"}, 32'(lat), 32'(exp_lat));
      if (!wr) check({name, "_rdata"}, drdata, e);
    end
    @(posedge clock); #1;
    dvalid = 1'b0; dwrite = 1'b0;
    @(negedge clock);
    check({name, "_wr_valid"}, 32'(wr_valid), 32'(wr & seen));
    if (wr) begin
      check({name, "_wr_addr"}, wr_addr, addr);
      check({name, "_wr_data"}, wr_data, wdata);
      check({name, "_wr_strb"}, 32'(wr_strb), 32'(strb));
      @(negedge clock);
      check({name, "_wr_pulse"}, 32'(wr_valid), 32'd0);
    end
  endtask

  task automatic limit_check();
    int rdy;
    check("limit_count", instr_count, 32'd4);
    check("limit_done", 32'(done), 32'd1);
    @(posedge clock); #1;
    ivalid = 1'b1; iwait = 2'd0; mode = 3'd0;
    rdy = 0;
    repeat (5) begin
      @(negedge clock);
      if (iready) rdy++;
    end
    check("limit_no_iready", 32'(rdy), 32'd0);
    check("limit_count_hold", instr_count, 32'd4);
    @(posedge clock); #1;
    ivalid = 1'b0;
    dreq("limit_dload", 1'b0, 32'h200, 32'h0, 4'h0, 2'd0, 32'hCAFEF00D, 0);
  endtask

  initial begin
    logic [3:0] pat;
    tests = 0; fails = 0;
    reset_n = 1'b1; iaddr = 32'h0; ivalid = 1'b0; daddr = 32'h0; dwdata = 32'h0;
    dstrb = 4'h0; dwrite = 1'b0; dvalid = 1'b0; mode = 3'd0; rs1 = 5'd0; rs2 = 5'd0;
    rd = 5'd0; imm = 12'h0; rdata_src = 32'h0; iwait = 2'd0; dwait = 2'd0;

    //        mode  rs1    rs2    rd     imm      wait lat  idata
    vecs[0] = '{3'd0, 5'd1,  5'd2,  5'd3,  12'h000, 2'd0, 0, 32'h002081B3};
    vecs[1] = '{3'd1, 5'd5,  5'd6,  5'd7,  12'h000, 2'd1, 1, 32'h406283B3};
    vecs[2] = '{3'd2, 5'd1,  5'd2,  5'd3,  12'h000, 2'd2, 2, 32'h0020F1B3};
    vecs[3] = '{3'd3, 5'd1,  5'd2,  5'd3,  12'h000, 2'd3, 2, 32'h0020E1B3};
    vecs[4] = '{3'd4, 5'd1,  5'd2,  5'd3,  12'h000, 2'd0, 0, 32'h0020C1B3};
    vecs[5] = '{3'd5, 5'd2,  5'd9,  5'd1,  12'h7FF, 2'd1, 1, 32'h7FF10093};
    vecs[6] = '{3'd6, 5'd31, 5'd31, 5'd31, 12'h000, 2'd3, 2, 32'h01FF8FB3};
    vecs[7] = '{3'd7, 5'd0,  5'd0,  5'd0,  12'hFFF, 2'd2, 2, 32'h00000033};
    vecs[8] = '{3'd5, 5'd0,  5'd4,  5'd31, 12'h800, 2'd0, 0, 32'h80000F93};

    for (int i = 0; i < 9; i++) begin
      if (i % 4 == 0) begin
        if (i > 0) limit_check();
        do_reset();
      end
      fetch(vecs[i], i, (i % 4) + 1);
    end

    // Both channels complete in the same cycle.
    do_reset();
    @(posedge clock); #1;
    mode = 3'd0; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3; iwait = 2'd0; ivalid = 1'b1;
    dwait = 2'd0; dwrite = 1'b0; rdata_src = 32'hA5A55A5A; dvalid = 1'b1;
    @(negedge clock);
    check("same_cycle_ready", 32'({iready, dready}), 32'd3);
    check("same_cycle_idata", idata, 32'h002081B3);
    check("same_cycle_drdata", drdata, 32'hA5A55A5A);

    // Back-to-back data requests with one wait state each.
    @(posedge clock); #1;
    ivalid = 1'b0; dwait = 2'd1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      pat[c] = dready;
    end
    @(posedge clock); #1;
    dvalid = 1'b0;
    @(negedge clock);
    check("b2b_ready_pattern", 32'(pat), 32'h0000000A);
    check("b2b_no_err", 32'(protocol_err), 32'd0);
    check("b2b_count", instr_count, 32'd1);

    dreq("load_w2", 1'b0, 32'h40, 32'h0, 4'h0, 2'd2, 32'hDEADBEEF, 2);
    dreq("load_w3_clamp", 1'b0, 32'h44, 32'h0, 4'h0, 2'd3, 32'h0BADF00D, 2);
    dreq("load_w0", 1'b0, 32'h48, 32'h0, 4'h0, 2'd0, 32'h13579BDF, 0);
    dreq("store", 1'b1, 32'h100, 32'h12345678, 4'hF, 2'd1, 32'h0, 1);
    dreq("store2", 1'b1, 32'h0FFC, 32'h89ABCDEF, 4'h3, 2'd0, 32'h0, 0);

    // Fetch withdrawn mid-wait.
    @(posedge clock); #1;
    iwait = 2'd2; ivalid = 1'b1;
    @(negedge clock);
    check("viol_no_ready0", 32'(iready), 32'd0);
    @(posedge clock); #1;
    ivalid = 1'b0;
    @(negedge clock);
    check("viol_no_ready1", 32'(iready), 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check("viol_err_set", 32'(protocol_err), 32'd1);
    check("viol_count", instr_count, 32'd1);
    repeat (3) @(negedge clock);
    check("viol_err_sticky", 32'(protocol_err), 32'd1);

    // reset_n asserted while both channels wait.
    @(posedge clock); #1;
    dwait = 2'd2; dvalid = 1'b1; iwait = 2'd2; ivalid = 1'b1;
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(negedge clock);
    check("abort_state", 32'({core_reset, iready, dready, protocol_err}), 32'h8);
    check("abort_count", instr_count, 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check("abort_no_ready", 32'({iready, dready}), 32'd0);
    do_reset();
    dreq("post_abort", 1'b0, 32'h80, 32'h0, 4'h0, 2'd2, 32'h600DCAFE, 2);

    check("sb_empty", 32'(iexp_q.size() + dexp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
